// File: rtl/temp_sample_ctrl_if.sv
// Sensor strobes plus the formatted temperature outputs of temp_sample_ctrl.
// sensor_start, sensor_done and force_sample are single-cycle strobes; sensor_data is qualified by sensor_done.
interface temp_sample_ctrl_if;
    logic        sensor_start;
    logic        sensor_done;
    logic [15:0] sensor_data;
    logic        force_sample;
    logic        temp_sign;
    logic [3:0]  temp_tens;
    logic [3:0]  temp_ones;
    logic [3:0]  temp_frac;
    logic        temp_valid;
    logic        over_range;
    logic        sensor_fault;

    modport master (
        output sensor_start, temp_sign, temp_tens, temp_ones, temp_frac,
               temp_valid, over_range, sensor_fault,
        input  sensor_done, sensor_data, force_sample
    );

    modport slave (
        input  sensor_start, temp_sign, temp_tens, temp_ones, temp_frac,
               temp_valid, over_range, sensor_fault,
        output sensor_done, sensor_data, force_sample
    );
endinterface

// File: rtl/temp_sample_ctrl.sv
// Periodic one-wire temperature sampler: requests a read, converts the raw
// 1/16 degC value to sign + BCD tens/units/tenths, and flags timeouts.
module temp_sample_ctrl #(
    parameter int SAMPLE_CYCLES  = 12000000,
    parameter int TIMEOUT_CYCLES = 24000000
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    temp_sample_ctrl_if.master  bus,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT    = 3'd2,
        CONVERT = 3'd3,
        UPDATE  = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [31:0] dwell_cnt;
    logic [31:0] timeout_cnt;
    logic        booted;
    logic        pending;
    logic        first_done;
    logic [7:0]  int_sh;
    logic [7:0]  bcd;
    logic [2:0]  bit_cnt;
    logic [3:0]  frac_q;
    logic        sign_q;
    logic        over_q;

    logic [15:0] mag_in;
    logic [3:0]  frac_in;
    logic [7:0]  bcd_adj;
    logic        dwell_hit;
    logic        timeout_hit;
    logic        discard;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    assign mag_in      = bus.sensor_data[15] ? (~bus.sensor_data + 16'd1) : bus.sensor_data;
    assign frac_in     = 4'(({4'b0000, mag_in[3:0]} * 8'd10) >> 4);
    assign bcd_adj     = {add3(bcd[7:4]), add3(bcd[3:0])};
    assign dwell_hit   = (dwell_cnt == 32'(SAMPLE_CYCLES - 1));
    assign timeout_hit = (timeout_cnt == 32'(TIMEOUT_CYCLES - 1));
    // Only the very first accepted read after reset may be the sensor's power-on value.
    assign discard     = !first_done && (bus.sensor_data == 16'h0550);

    assign bus.sensor_start = (state == START);
    assign state_dbg        = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!booted || dwell_hit || pending || bus.force_sample) state_next = START;
            START:   state_next = WAIT;
            WAIT: begin
                if (bus.sensor_done)  state_next = discard ? START : CONVERT;
                else if (timeout_hit) state_next = IDLE;
            end
            CONVERT: if (bit_cnt == 3'd7) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= IDLE;
            dwell_cnt        <= '0;
            timeout_cnt      <= '0;
            booted           <= 1'b0;
            pending          <= 1'b0;
            first_done       <= 1'b0;
            int_sh           <= '0;
            bcd              <= '0;
            bit_cnt          <= '0;
            frac_q           <= '0;
            sign_q           <= 1'b0;
            over_q           <= 1'b0;
            bus.temp_sign    <= 1'b0;
            bus.temp_tens    <= '0;
            bus.temp_ones    <= '0;
            bus.temp_frac    <= '0;
            bus.temp_valid   <= 1'b0;
            bus.over_range   <= 1'b0;
            bus.sensor_fault <= 1'b0;
        end else begin
            state  <= state_next;
            booted <= 1'b1;

            // Dwell restarts from zero on every IDLE entry, not on a fixed cadence.
            if (state == IDLE && state_next == IDLE) dwell_cnt <= dwell_cnt + 32'd1;
            else                                     dwell_cnt <= '0;

            if (state == IDLE) begin
                if (state_next == START) pending <= 1'b0;
            end else if (bus.force_sample) begin
                pending <= 1'b1;
            end

            case (state)
                START: timeout_cnt <= '0;
                WAIT: begin
                    if (bus.sensor_done) begin
                        first_done <= 1'b1;
                        int_sh     <= mag_in[11:4];
                        frac_q     <= frac_in;
                        sign_q     <= bus.sensor_data[15] && (mag_in != 16'd0);
                        over_q     <= (mag_in[11:4] > 8'd99);
                        bcd        <= '0;
                        bit_cnt    <= '0;
                    end else if (timeout_hit) begin
                        bus.sensor_fault <= 1'b1;
                        bus.temp_valid   <= 1'b0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 32'd1;
                    end
                end
                CONVERT: begin
                    // Hundreds digit falls off the top; it only matters when clamped anyway.
                    {bcd, int_sh} <= {bcd_adj, int_sh} << 1;
                    bit_cnt       <= bit_cnt + 3'd1;
                end
                UPDATE: begin
                    bus.temp_sign    <= sign_q;
                    bus.temp_tens    <= over_q ? 4'd9 : bcd[7:4];
                    bus.temp_ones    <= over_q ? 4'd9 : bcd[3:0];
                    bus.temp_frac    <= over_q ? 4'd9 : frac_q;
                    bus.over_range   <= over_q;
                    bus.temp_valid   <= 1'b1;
                    bus.sensor_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Self-checking bench for temp_sample_ctrl: scripted sensor responses,
// expected display words queued at stimulus time and checked at update time.
module tb_temp_sample_ctrl;

    localparam int SAMPLE  = 40;
    localparam int TIMEOUT = 30;
    localparam int W       = 14;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state_dbg;

    temp_sample_ctrl_if bus();

    temp_sample_ctrl #(
        .SAMPLE_CYCLES (SAMPLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int             vectors = 0;
    int             miscompares = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   last_out;

    // {sign, tens, ones, frac, over_range}
    function automatic logic [W-1:0] out_now();
        return {bus.temp_sign, bus.temp_tens, bus.temp_ones, bus.temp_frac, bus.over_range};
    endfunction

    function automatic logic [W-1:0] model(input logic [15:0] d);
        logic [15:0] m;
        int          ip, fr;
        logic        s, ov;
        m  = d[15] ? (16'h0000 - d) : d;
        ip = int'(m[11:4]);
        fr = (int'(m[3:0]) * 10) / 16;
        s  = d[15] && (m != 16'h0000);
        ov = (ip > 99);
        if (ov) return {s, 4'd9, 4'd9, 4'd9, 1'b1};
        return {s, 4'(ip / 10), 4'(ip % 10), 4'(fr), 1'b0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        while (bus.sensor_start !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Entered during the START cycle; answers the read and checks the update.
    task automatic do_read(input logic [15:0] data, input int nforce, input string name);
        logic [W-1:0] exp;
        tick();
        vectors++;
        if (bus.sensor_start !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_start_width: sensor_start=%b required 0", name, bus.sensor_start);
        end
        if (nforce == 0) repeat ($urandom_range(0, 3)) tick();
        for (int i = 0; i < nforce; i++) begin
            bus.force_sample = 1'b1;
            tick();
            bus.force_sample = 1'b0;
            tick();
        end
        bus.sensor_done = 1'b1;
        bus.sensor_data = data;
        exp_q.push_back(model(data));
        tick();
        bus.sensor_done = 1'b0;
        bus.sensor_data = 16'($urandom);
        repeat (8) tick();
        vectors++;
        if (out_now() !== last_out) begin
            miscompares++;
            $display("FAIL %s_early_update: got %h required %h", name, out_now(), last_out);
        end
        tick();
        exp = exp_q.pop_front();
        vectors++;
        if ({out_now(), bus.temp_valid, bus.sensor_fault} !== {exp, 2'b10}) begin
            miscompares++;
            $display("FAIL %s_update: got %h v%b f%b required %h v1 f0", name, out_now(),
                     bus.temp_valid, bus.sensor_fault, exp);
        end
        last_out = exp;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.sensor_done  = 1'b0;
        bus.sensor_data  = 16'h0000;
        bus.force_sample = 1'b0;
        last_out = '0;
        repeat (3) tick();
        vectors++;
        if ({out_now(), bus.temp_valid, bus.sensor_fault, bus.sensor_start, state_dbg} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h v%b f%b s%b st%0d required all 0", out_now(),
                     bus.temp_valid, bus.sensor_fault, bus.sensor_start, state_dbg);
        end
        rst_n = 1'b1;
        vectors++;
        if (bus.sensor_start !== 1'b0) begin
            miscompares++;
            $display("FAIL start_before_edge: sensor_start=%b required 0", bus.sensor_start);
        end
        tick();
        vectors++;
        if (bus.sensor_start !== 1'b1) begin
            miscompares++;
            $display("FAIL first_start: sensor_start=%b required 1", bus.sensor_start);
        end
    endtask

    task automatic test_first_sample();
        do_read(16'h0191, 0, "first");
        vectors++;
        if (out_now() !== {1'b0, 4'd2, 4'd5, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL first_digits: got %h required 2/5/0 positive", out_now());
        end
    endtask

    task automatic test_negative();
        int n;
        wait_start(SAMPLE + 5, n);
        vectors++;
        if (n != SAMPLE) begin
            miscompares++;
            $display("FAIL dwell_period: got %0d cycles required %0d", n, SAMPLE);
        end
        do_read(16'hFF5E, 0, "negative");
        vectors++;
        if (out_now() !== {1'b1, 4'd1, 4'd0, 4'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL negative_digits: got %h required -1/0/1", out_now());
        end
    endtask

    task automatic test_ignore_done_and_over();
        int n;
        bus.sensor_done = 1'b1;
        bus.sensor_data = 16'h07D0;
        tick();
        bus.sensor_done = 1'b0;
        wait_start(SAMPLE + 5, n);
        vectors++;
        if (n != SAMPLE - 1 || out_now() !== last_out) begin
            miscompares++;
            $display("FAIL idle_done_ignored: got %0d cycles out %h required %0d out %h",
                     n, out_now(), SAMPLE - 1, last_out);
        end
        do_read(16'h07D0, 0, "over");
        vectors++;
        if (out_now() !== {1'b0, 4'd9, 4'd9, 4'd9, 1'b1}) begin
            miscompares++;
            $display("FAIL over_digits: got %h required 9/9/9 over", out_now());
        end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 4; i++) begin
            wait_start(SAMPLE + 5, n);
            vectors++;
            if (bus.sensor_start !== 1'b1) begin
                miscompares++;
                $display("FAIL random_start: no sensor_start after %0d cycles", n);
            end
            do_read(16'($urandom_range(0, 65535)), 0, "random");
        end
    endtask

    task automatic test_timeout();
        int n;
        wait_start(SAMPLE + 5, n);
        tick();
        repeat (TIMEOUT - 1) tick();
        vectors++;
        if ({bus.sensor_fault, bus.temp_valid} !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_early: fault=%b valid=%b required 0 1", bus.sensor_fault, bus.temp_valid);
        end
        tick();
        vectors++;
        if ({bus.sensor_fault, bus.temp_valid, out_now(), state_dbg} !== {2'b10, last_out, 3'd0}) begin
            miscompares++;
            $display("FAIL timeout: fault=%b valid=%b out %h st%0d required 1 0 %h st0",
                     bus.sensor_fault, bus.temp_valid, out_now(), state_dbg, last_out);
        end
        wait_start(SAMPLE + 5, n);
        vectors++;
        if (n != SAMPLE) begin
            miscompares++;
            $display("FAIL timeout_dwell: got %0d cycles required %0d", n, SAMPLE);
        end
        do_read(16'h0234, 0, "recover");
    endtask

    task automatic test_back_to_back();
        int n;
        wait_start(SAMPLE + 5, n);
        do_read(16'h0123, 2, "pend");
        wait_start(3, n);
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL pending_start: got %0d cycles required 1", n);
        end
        do_read(16'h0456, 0, "pend_read");
        wait_start(SAMPLE + 5, n);
        vectors++;
        if (n != SAMPLE) begin
            miscompares++;
            $display("FAIL pending_collapse: got %0d cycles required %0d", n, SAMPLE);
        end
        do_read(16'hFE00, 0, "after_pend");
        bus.force_sample = 1'b1;
        tick();
        bus.force_sample = 1'b0;
        vectors++;
        if (bus.sensor_start !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_force: sensor_start=%b required 1", bus.sensor_start);
        end
        do_read(16'h0008, 0, "forced");
    endtask

    task automatic test_power_on_discard();
        int n;
        wait_start(SAMPLE + 5, n);
        tick();
        bus.sensor_done = 1'b1;
        bus.sensor_data = 16'h0191;
        tick();
        bus.sensor_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_now(), bus.temp_valid, bus.sensor_fault, bus.sensor_start, state_dbg} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_abort: got %h v%b st%0d required all 0", out_now(), bus.temp_valid, state_dbg);
        end
        last_out = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        tick();
        bus.sensor_done = 1'b1;
        bus.sensor_data = 16'h0550;
        tick();
        bus.sensor_done = 1'b0;
        wait_start(2, n);
        vectors++;
        if (bus.sensor_start !== 1'b1 || out_now() !== '0 || bus.temp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL discard: start=%b out %h valid=%b required 1 0000 0",
                     bus.sensor_start, out_now(), bus.temp_valid);
        end
        do_read(16'h0550, 0, "second_0550");
        vectors++;
        if (out_now() !== {1'b0, 4'd8, 4'd5, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL accept_0550: got %h required 8/5/0", out_now());
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_negative();
        test_ignore_done_and_over();
        test_random();
        test_timeout();
        test_back_to_back();
        test_power_on_discard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
